fifo_uart_tx: RTL and testbench

- Downstream consumer of the 16-bit, 8-deep FIFO.
- Pops one word at a time through the FIFO read port (RD/VALID/EMPTY/DOUT).
- Serializes each word as two UART 8N1 frames on TXD, low byte first by default.
- Sits between the FIFO and the board serial pin; it is the drain that empties the FIFO.

---
 rtl/fifo_uart_tx.sv | 238 +++++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
//------------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain for a 16-bit FIFO: pops one word at a time through the FIFO read port
// and sends it on TXD as two UART frames. The low byte goes first unless
// LOW_BYTE_FIRST is 0.
//
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit
// after each data byte. This turns 8N1 frames (10 bit times) into 8E1 frames
// (11 bit times). Without the macro the PARITY state does not exist.
//
// Every output comes straight from a flop. TXD idles high and is forced high
// by reset, so a reset in the middle of a frame abandons the word at once.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT   = 87,    // clock cycles per UART bit, >= 2
    parameter bit LOW_BYTE_FIRST = 1'b1,  // 1: DOUT[7:0] goes first
    parameter int VALID_TIMEOUT  = 4      // max cycles spent in WAIT for VALID
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        FIFO_EMPTY,
    input  logic        FIFO_VALID,
    input  logic [15:0] FIFO_DOUT,
    output logic        FIFO_RD,
    output logic        TXD,
    output logic        BUSY,
    output logic        ERR
);

    // Counter widths. The baud counter runs 0..CLKS_PER_BIT-1. The WAIT counter
    // runs 0..VALID_TIMEOUT-1.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TO_W   = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(VALID_TIMEOUT - 1);

    // Controller states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif
    localparam logic [2:0] S_STOP   = 3'd6;

    // State and datapath registers
    logic [2:0]        state_q,    state_d;
    logic [BAUD_W-1:0] baud_q,     baud_d;
    logic [2:0]        bit_q,      bit_d;
    logic              byte_idx_q, byte_idx_d;
    logic [TO_W-1:0]   wait_q,     wait_d;
    logic [15:0]       shadow_q,   shadow_d;

    // Output registers
    logic txd_q,  txd_d;
    logic rd_q,   rd_d;
    logic busy_q, busy_d;
    logic err_q,  err_d;

    // Helper signals
    logic       baud_done;
    logic       sel_hi;
    logic [7:0] cur_byte;
    logic [2:0] bit_nxt;

    // The current bit time ends on the last cycle of the baud counter.
    always_comb begin
        baud_done = (baud_q == BAUD_LAST);
        bit_nxt   = bit_q + 3'd1;
    end

    // Pick the byte being sent from the shadow word.
    // byte_idx 0 is the first byte on the wire.
    always_comb begin
        sel_hi   = LOW_BYTE_FIRST ? byte_idx_q : ~byte_idx_q;
        cur_byte = sel_hi ? shadow_q[15:8] : shadow_q[7:0];
    end

    // Next-state and next-output logic for the fetch / serialise sequence.
    always_comb begin
        // NOTE: every signal assigned below gets a default first. A path that
        // skips an assignment then holds the value in a flop, not a latch.
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_idx_d = byte_idx_q;
        wait_d     = wait_q;
        shadow_d   = shadow_q;
        txd_d      = txd_q;
        rd_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                // FIFO_EMPTY is only looked at here. That keeps RD away from
                // an empty FIFO.
                if (ENABLE && !FIFO_EMPTY) begin
                    state_d = S_FETCH;
                    rd_d    = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end

            S_WAIT: begin
                if (FIFO_VALID) begin
                    shadow_d   = FIFO_DOUT;
                    byte_idx_d = 1'b0;
                    baud_d     = '0;
                    txd_d      = 1'b0;
                    state_d    = S_START;
                end else if (wait_q == TO_LAST) begin
                    // Give up on this fetch. IDLE retries it later.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        txd_d   = ^cur_byte;
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!byte_idx_q) begin
                        // The second byte follows with no idle gap.
                        byte_idx_d = 1'b1;
                        txd_d      = 1'b0;
                        state_d    = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output flops. Reset puts the block in IDLE with TXD high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            byte_idx_q <= 1'b0;
            wait_q     <= '0;
            shadow_q   <= 16'h0000;
            txd_q      <= 1'b1;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only. Every flop samples the
            // pre-edge values, whatever order these lines are written in.
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            shadow_q   <= shadow_d;
            txd_q      <= txd_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Outputs come straight from their flops.
    always_comb begin
        TXD     = txd_q;
        FIFO_RD = rd_q;
        BUSY    = busy_q;
        ERR     = err_q;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
//------------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two copies of fifo_uart_tx share one behavioural FIFO: u_lo sends the low
// byte first and u_hi sends the high byte first.
// Each word popped by the FIFO model pushes the bytes it should produce onto a
// per-copy expected queue. A UART receiver per copy decodes TXD cycle by cycle.
// It checks framing and bit width, then pops and compares each byte.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_uart_tx;

    localparam int N  = 4;   // CLKS_PER_BIT
    localparam int TO = 4;   // VALID_TIMEOUT
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int WORD_CYCLES = 2 * FRAME_BITS * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_valid = 1'b0;
    logic [15:0] fifo_dout = 16'h0000;
    logic        fifo_empty;
    logic        rd_a, txd_a, busy_a, err_a;
    logic        rd_b, txd_b, busy_b, err_b;

    // Behavioural FIFO contents and scoreboard queues
    logic [15:0] fifo_q [$];
    logic [7:0]  exp_a  [$];
    logic [7:0]  exp_b  [$];
    logic [15:0] popped;
    bit          hold_valid = 1'b0;
    bit          expect_err = 1'b0;
    bit          rd_prev = 1'b0;
    int          rd_count = 0;
    int          under_count = 0;
    int          rd_wide = 0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(N), .LOW_BYTE_FIRST(1'b1), .VALID_TIMEOUT(TO)) u_lo (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .FIFO_EMPTY(fifo_empty),
        .FIFO_VALID(fifo_valid), .FIFO_DOUT(fifo_dout), .FIFO_RD(rd_a),
        .TXD(txd_a), .BUSY(busy_a), .ERR(err_a)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(N), .LOW_BYTE_FIRST(1'b0), .VALID_TIMEOUT(TO)) u_hi (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .FIFO_EMPTY(fifo_empty),
        .FIFO_VALID(fifo_valid), .FIFO_DOUT(fifo_dout), .FIFO_RD(rd_b),
        .TXD(txd_b), .BUSY(busy_b), .ERR(err_b)
    );

    assign fifo_empty = (fifo_q.size() == 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // FIFO read port model. VALID and DOUT appear the cycle after RD.
    always @(posedge clk) begin
        if (!rst_n) begin
            fifo_valid <= 1'b0;
            rd_prev = 1'b0;
        end else begin
            fifo_valid <= 1'b0;
            if (rd_a) begin
                rd_count++;
                if (fifo_q.size() == 0) under_count++;
                else if (!hold_valid) begin
                    popped = fifo_q.pop_front();
                    fifo_dout  <= popped;
                    fifo_valid <= 1'b1;
                    exp_a.push_back(popped[7:0]);
                    exp_a.push_back(popped[15:8]);
                    exp_b.push_back(popped[15:8]);
                    exp_b.push_back(popped[7:0]);
                end
            end
            if (rd_a && rd_prev) rd_wide++;
            rd_prev = rd_a;
        end
    end

    // ERR is only legal during the timeout scenario.
    always @(negedge clk) begin
        if (rst_n && !expect_err && (err_a || err_b))
            check("err_spurious", 32'(err_a | err_b), 32'd0);
    end

    // Receive one frame. The caller has already seen the first start-bit cycle.
    task automatic rx_frame(input int ch, output bit aborted, output logic [7:0] data,
                            output bit ok);
        logic cur;
        logic bitval;
        aborted = 1'b0;
        ok      = 1'b1;
        data    = 8'h00;
        bitval  = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < N; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    return;
                end
                cur = (ch == 0) ? txd_a : txd_b;
                if (c == 0) bitval = cur;
                else if (cur !== bitval) ok = 1'b0;
            end
            if (b == 0 && bitval !== 1'b0) ok = 1'b0;
            if (b >= 1 && b <= 8) data[b-1] = bitval;
            if (FRAME_BITS == 11 && b == 9 && bitval !== ^data) ok = 1'b0;
            if (b == FRAME_BITS - 1 && bitval !== 1'b1) ok = 1'b0;
        end
    endtask

    // Per-channel monitor: decode frames and compare against the scoreboard.
    task automatic monitor(input int ch);
        logic [7:0] data;
        logic [7:0] want;
        bit         aborted;
        bit         ok;
        int         nfr;
        int         pending;
        nfr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) nfr = 0;
            else if (((ch == 0) ? txd_a : txd_b) === 1'b0) begin
                rx_frame(ch, aborted, data, ok);
                if (aborted) nfr = 0;
                else begin
                    check((ch == 0) ? "framing_lo" : "framing_hi", 32'(ok), 32'd1);
                    pending = (ch == 0) ? exp_a.size() : exp_b.size();
                    check((ch == 0) ? "frame_expected_lo" : "frame_expected_hi",
                          32'(pending > 0), 32'd1);
                    if (pending > 0) begin
                        if (ch == 0) want = exp_a.pop_front();
                        else         want = exp_b.pop_front();
                        check((ch == 0) ? "byte_lo" : "byte_hi", 32'(data), 32'(want));
                    end
                    nfr++;
                    if (nfr == 2) begin
                        nfr = 0;
                        @(negedge clk);
                        if (rst_n)
                            check((ch == 0) ? "idle_gap_lo" : "idle_gap_hi",
                                  32'((ch == 0) ? busy_a : busy_b), 32'd0);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Wait until the FIFO is drained and both copies are idle.
    task automatic wait_drain(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (!(fifo_q.size() == 0 && !busy_a && !busy_b) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check(name, 32'(fifo_q.size() == 0 && !busy_a && !busy_b), 32'd1);
    endtask

    task automatic wait_txd_low(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (txd_a !== 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(txd_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rd0;
        int cyc;
        int busy_len;
        int first_low;
        bit saw_low;
        logic [31:0] err_at [0:TO+2];

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd",  32'({txd_a, txd_b}), 32'd3);
        check("reset_busy", 32'({busy_a, busy_b}), 32'd0);
        check("reset_rd",   32'({rd_a, rd_b}), 32'd0);
        check("reset_err",  32'({err_a, err_b}), 32'd0);
        rst_n = 1'b1;

        // Enabled but empty: must stay idle
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("empty_idle_busy", 32'(busy_a), 32'd0);
        check("empty_idle_rd",   32'(rd_count), 32'd0);

        // Single word: RD pulse, start bit two cycles later, 80 cycles of activity
        rd0 = rd_count;
        fifo_q.push_back(16'hA55A);
        cyc = 0;
        while (!rd_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("single_rd_seen", 32'(rd_a), 32'd1);
        busy_len  = 0;
        first_low = -1;
        while (busy_a && busy_len < 400) begin
            if (txd_a === 1'b0 && first_low < 0) first_low = busy_len;
            busy_len++;
            @(negedge clk);
        end
        check("single_start_offset", 32'(first_low), 32'd2);
        check("single_busy_len", 32'(busy_len), 32'(2 + WORD_CYCLES));
        wait_drain("single_drain", 50);
        check("single_rd_count", 32'(rd_count - rd0), 32'd1);

        // Back-to-back words
        rd0 = rd_count;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'h8000);
        fifo_q.push_back(16'hFFFF);
        wait_drain("b2b_drain", 3 * (WORD_CYCLES + 10));
        check("b2b_rd_count", 32'(rd_count - rd0), 32'd3);
        check("b2b_empty", 32'(fifo_empty), 32'd1);

        // Random words, plus 0x0307 for its parity-1 and parity-0 bytes
        rd0 = rd_count;
        fifo_q.push_back(16'h0307);
        for (int i = 0; i < 5; i++) fifo_q.push_back(16'($urandom));
        wait_drain("rand_drain", 6 * (WORD_CYCLES + 10));
        check("rand_rd_count", 32'(rd_count - rd0), 32'd6);

        // ENABLE drop during the first byte: word finishes, no further fetch
        rd0 = rd_count;
        fifo_q.push_back(16'($urandom));
        fifo_q.push_back(16'($urandom));
        wait_txd_low("endrop_start", 20);
        enable = 1'b0;
        cyc = 0;
        while (busy_a && cyc < WORD_CYCLES + 20) begin
            @(negedge clk);
            cyc++;
        end
        repeat (WORD_CYCLES) @(negedge clk);
        check("endrop_busy", 32'(busy_a), 32'd0);
        check("endrop_rd_count", 32'(rd_count - rd0), 32'd1);
        check("endrop_left", 32'(fifo_q.size()), 32'd1);
        check("endrop_sent", 32'(exp_a.size() + exp_b.size()), 32'd0);
        enable = 1'b1;
        wait_drain("endrop_drain", WORD_CYCLES + 20);

        // VALID timeout: ERR pulse TO cycles after WAIT entry, then retry
        expect_err = 1'b1;
        hold_valid = 1'b1;
        fifo_q.push_back(16'h5A3C);
        cyc = 0;
        while (!rd_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("to_rd_seen", 32'(rd_a), 32'd1);
        saw_low = 1'b0;
        for (int k = 1; k <= TO + 2; k++) begin
            @(negedge clk);
            err_at[k] = 32'(err_a);
            if (txd_a !== 1'b1) saw_low = 1'b1;
        end
        check("to_err_early", err_at[TO], 32'd0);
        check("to_err_pulse", err_at[TO+1], 32'd1);
        check("to_err_single", err_at[TO+2], 32'd0);
        check("to_retry_rd", 32'(rd_a), 32'd1);
        check("to_txd_quiet", 32'(saw_low), 32'd0);
        enable = 1'b0;
        cyc = 0;
        while (busy_a && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("to_stop", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);
        expect_err = 1'b0;
        hold_valid = 1'b0;
        enable = 1'b1;
        wait_drain("to_drain", WORD_CYCLES + 20);

        // Asynchronous reset in the middle of the DATA bits
        fifo_q.push_back(16'hC3A5);
        wait_txd_low("rst_start", 20);
        repeat (3 * N) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_txd",  32'({txd_a, txd_b}), 32'd3);
        check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("rst_rd",   32'({rd_a, rd_b}), 32'd0);
        repeat (2) @(negedge clk);
        exp_a.delete();
        exp_b.delete();
        rst_n = 1'b1;
        rd0 = rd_count;
        repeat (20) @(negedge clk);
        check("rst_after_busy", 32'(busy_a), 32'd0);
        check("rst_after_rd",   32'(rd_count - rd0), 32'd0);
        check("rst_after_txd",  32'(txd_a), 32'd1);

        // Global bookkeeping
        check("under_count", 32'(under_count), 32'd0);
        check("rd_pulse_width", 32'(rd_wide), 32'd0);
        check("exp_lo_empty", 32'(exp_a.size()), 32'd0);
        check("exp_hi_empty", 32'(exp_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
